// File: rtl/axi4_lite_slave_regfile_pkg.sv
// Purpose: shared AXI4-Lite response codes and FSM state encodings for the register-file slave.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package axi4_lite_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    // Write channel FSM
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;

    // Read channel FSM
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

endpackage

// File: rtl/axi4_lite_slave_regfile_if.sv
// Purpose: AXI4-Lite bundle (AW, W, B, AR, R channels) with master and slave views.
// Latency: n/a (wires only).
// Backpressure: every channel carries its own VALID/READY pair.
interface axi4_lite_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) ();
    import axi4_lite_pkg::*;

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;

    logic                  bvalid;
    logic                  bready;
    resp_t                 bresp;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    resp_t                 rresp;

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi4_lite_slave_regfile_strb_merge.sv
// Purpose: per-byte merge of an old word with new data under a byte-strobe mask.
// Latency: combinational.
// Backpressure: none.
// Ports: old_i (current word), new_i (write data), strb_i (byte enables), merged_o (result).
module axi4_lite_strb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_i,
    input  logic [DATA_WIDTH-1:0]   new_i,
    input  logic [DATA_WIDTH/8-1:0] strb_i,
    output logic [DATA_WIDTH-1:0]   merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (strb_i[b]) begin
                merged_o[8*b +: 8] = new_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// Purpose: AXI4-Lite slave register file with byte-strobe writes, DECERR on unmapped words, parallel export.
// Latency: write response the edge after both AW and W are present; read data one cycle after AR.
// Backpressure: one outstanding write and one outstanding read; B/R held stable until bready/rready.
// Ports: aclk/aresetn, s_axi (AXI4-Lite slave modport), reg_q (all registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]).
module axi4_lite_slave_regfile
    import axi4_lite_pkg::*;
#(
    parameter  int ADDR_WIDTH = 8,
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_REGS   = 16,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    axi4_lite_if.slave                     s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

    localparam int OFF   = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - OFF;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    // ---------------- write side ----------------
    logic [0:0]            w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q,   wstrb_d;
    resp_t                 bresp_q,   bresp_d;

    logic                  aw_hs, w_hs, wr_commit, wr_mapped;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged;
    logic [STRB_WIDTH-1:0] wr_strb;

    // Ready is gated by aresetn so it reads 0 while reset is held.
    assign s_axi.awready = aresetn && (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axi.wready  = aresetn && (w_state_q == W_IDLE) && !w_held_q;
    assign s_axi.bvalid  = (w_state_q == W_RESP);
    assign s_axi.bresp   = bresp_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid  && s_axi.wready;

    // Take each half from the holding register if already captured, else straight
    // from the bus, so a same-cycle or completing handshake commits on this edge.
    assign wr_addr   = aw_held_q ? awaddr_q : s_axi.awaddr;
    assign wr_data   = w_held_q  ? wdata_q  : s_axi.wdata;
    assign wr_strb   = w_held_q  ? wstrb_q  : s_axi.wstrb;
    assign wr_idx    = wr_addr[ADDR_WIDTH-1:OFF];
    assign wr_mapped = 32'(wr_idx) < NUM_REGS;
    assign wr_commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    axi4_lite_strb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
        .old_i    (wr_old),
        .new_i    (wr_data),
        .strb_i   (wr_strb),
        .merged_o (wr_merged)
    );

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        if (w_state_q == W_IDLE) begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi.awaddr;
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi.wdata;
                wstrb_d  = s_axi.wstrb;
            end
            if (wr_commit) begin
                w_state_d = W_RESP;
                bresp_d   = wr_mapped ? RESP_OKAY : RESP_DECERR;
            end
        end else if (s_axi.bready) begin
            w_state_d = W_IDLE;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
        end
    end

    // ---------------- read side ----------------
    logic [0:0]            r_state_q;
    resp_t                 rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_mapped;
    logic [DATA_WIDTH-1:0] rd_word;

    assign s_axi.arready = aresetn && (r_state_q == R_IDLE);
    assign s_axi.rvalid  = (r_state_q == R_DATA);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign rd_idx    = s_axi.araddr[ADDR_WIDTH-1:OFF];
    assign rd_mapped = 32'(rd_idx) < NUM_REGS;

    // Index muxes; unmapped indices match no entry and yield 0.
    always_comb begin
        wr_old  = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) wr_old  = regs_q[i];
            if (rd_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    // rd_word samples regs_q before this edge's commit lands, so a read accepted
    // on the commit edge returns the pre-write value.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else if (r_state_q == R_IDLE) begin
            if (s_axi.arvalid) begin
                r_state_q <= R_DATA;
                rdata_q   <= rd_mapped ? rd_word : '0;
                rresp_q   <= rd_mapped ? RESP_OKAY : RESP_DECERR;
            end
        end else if (s_axi.rready) begin
            r_state_q <= R_IDLE;
        end
    end

    // ---------------- register storage ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wr_commit && wr_mapped) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) regs_q[i] <= wr_merged;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    // Protection bits and sub-word address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, wr_addr[OFF-1:0], s_axi.araddr[OFF-1:0]};

endmodule
